// File: rtl/cbfp_pkg.sv
// rtl/cbfp_pkg.sv - shared types and sizes for the post-CBFP block alignment stage
package cbfp_pkg;
    localparam int ARRAY_SIZE      = 16;
    localparam int DIN_SIZE        = 11;
    localparam int CNT_SIZE        = 5;
    localparam int BEATS_PER_BLOCK = 4;
    localparam int SLOT_W          = $clog2(BEATS_PER_BLOCK);

    typedef logic signed [DIN_SIZE-1:0] sample_t;
    typedef sample_t                    lane_vec_t [ARRAY_SIZE];
    typedef logic [CNT_SIZE-1:0]        zcnt_t;
    typedef logic [SLOT_W-1:0]          slot_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_OUT  = 1'b1
    } rd_state_t;

    localparam slot_t LAST_SLOT   = slot_t'(BEATS_PER_BLOCK - 1);
    localparam zcnt_t SHIFT_CLAMP = zcnt_t'(DIN_SIZE - 1);

    function automatic zcnt_t zcnt_min(input zcnt_t a, input zcnt_t b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/cbfp_lane_shift.sv
// rtl/cbfp_lane_shift.sv - one lane of arithmetic right shift with sign-fill clamp
module cbfp_lane_shift
    import cbfp_pkg::*;
(
    input  sample_t     i_din,
    input  zcnt_t       i_shift,
    output sample_t     o_dout
);
    logic    w_clamp;
    sample_t w_fill;

    // Past DIN_SIZE-1 positions only sign bits remain, so force the fill directly.
    assign w_clamp = (i_shift >= SHIFT_CLAMP);
    assign w_fill  = sample_t'({DIN_SIZE{i_din[DIN_SIZE-1]}});
    assign o_dout  = w_clamp ? w_fill : (i_din >>> i_shift);
endmodule

// File: rtl/cbfp_block_align.sv
// rtl/cbfp_block_align.sv - ping-pong block buffer re-aligning 4-beat blocks to a shared exponent
module cbfp_block_align
    import cbfp_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    input  logic      valid_in,
    input  lane_vec_t din_re_p,
    input  zcnt_t     zero_cnt_in,
    output logic      valid_out,
    output lane_vec_t dout_re_p,
    output zcnt_t     blk_exp_out,
    output logic      blk_first_out
);
    lane_vec_t r_mem     [2][BEATS_PER_BLOCK];
    zcnt_t     r_cnt_mem [2][BEATS_PER_BLOCK];
    zcnt_t     r_bank_min[2];
    zcnt_t     r_run_min;

    slot_t     r_wr_cnt;
    logic      r_wr_bank;
    logic [1:0] r_full;
    slot_t     r_rd_cnt;
    logic      r_rd_bank;
    rd_state_t r_state;
    rd_state_t w_next_state;

    logic       w_emit;
    logic       w_wr_last;
    zcnt_t      w_new_min;
    logic [1:0] w_set;
    logic [1:0] w_clr;
    lane_vec_t  w_rd_beat;
    zcnt_t      w_rd_min;
    zcnt_t      w_shift;
    lane_vec_t  w_aligned;

    lane_vec_t r_dout;
    logic      r_valid;
    zcnt_t     r_exp;
    logic      r_first;

    assign w_wr_last = valid_in && (r_wr_cnt == LAST_SLOT);
    assign w_new_min = (r_wr_cnt == '0) ? zero_cnt_in : zcnt_min(r_run_min, zero_cnt_in);

    // Buffer storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            r_mem[r_wr_bank][r_wr_cnt]     <= din_re_p;
            r_cnt_mem[r_wr_bank][r_wr_cnt] <= zero_cnt_in;
            r_run_min                      <= w_new_min;
            if (w_wr_last) begin
                r_bank_min[r_wr_bank] <= w_new_min;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (valid_in) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_wr_last) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // IDLE emits slot 0 on the same edge it sees a full bank, giving one-edge latency.
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_emit       = 1'b1;
                    w_next_state = RD_OUT;
                end
            end
            RD_OUT: begin
                w_emit = 1'b1;
                if (r_rd_cnt == LAST_SLOT) begin
                    w_next_state = r_full[~r_rd_bank] ? RD_OUT : RD_IDLE;
                end
            end
            default: w_next_state = RD_IDLE;
        endcase
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_wr_last) begin
            w_set[r_wr_bank] = 1'b1;
        end
        if (w_emit && (r_rd_cnt == LAST_SLOT)) begin
            w_clr[r_rd_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_full    <= '0;
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            r_full <= (r_full & ~w_clr) | w_set;
            if (w_emit) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if (r_rd_cnt == LAST_SLOT) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
        end
    end

    assign w_rd_beat = r_mem[r_rd_bank][r_rd_cnt];
    assign w_rd_min  = r_bank_min[r_rd_bank];
    assign w_shift   = r_cnt_mem[r_rd_bank][r_rd_cnt] - w_rd_min;

    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
        cbfp_lane_shift u_lane_shift (
            .i_din   (w_rd_beat[g]),
            .i_shift (w_shift),
            .o_dout  (w_aligned[g])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_dout  <= '{default: '0};
            r_exp   <= '0;
            r_first <= 1'b0;
        end else begin
            r_valid <= w_emit;
            r_first <= w_emit && (r_rd_cnt == '0);
            if (w_emit) begin
                r_dout <= w_aligned;
                if (r_rd_cnt == '0) begin
                    r_exp <= w_rd_min;
                end
            end
        end
    end

    assign valid_out     = r_valid;
    assign dout_re_p     = r_dout;
    assign blk_exp_out   = r_exp;
    assign blk_first_out = r_first;
endmodule

// File: doc/cbfp_block_align.md
# cbfp_block_align

Post-CBFP alignment stage. It consumes the 16-lane, 11-bit normalized samples from the CBFP block, together with each beat's 5-bit zero count. It collects each 64-sample block (4 beats) in a ping-pong buffer and re-aligns all beats to the block's minimum zero count, so the whole block shares one exponent. It then streams the aligned block out as 4 consecutive beats for the next FFT stage.

## Interface
- `array_size`, 16, lanes per beat
- `din_size`, 11, input sample width (signed)
- `dout_size`, 11, output sample width (signed); equals `din_size`
- `cnt_size`, 5, zero-count / exponent width (unsigned)
- `beats_per_block`, 4, beats per 64-sample block

- `clk`  in  1  sole clock; all state on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `valid_in`  in  1  beat qualifier for `din_re_p` / `zero_cnt_in`
- `din_re_p`  in  `din_size` x `array_size`  normalized samples, lane 0..15
- `zero_cnt_in`  in  `cnt_size`  zero count (left-shift applied by CBFP) for this beat
- `valid_out`  out  1  aligned beat valid
- `dout_re_p`  out  `dout_size` x `array_size`  aligned samples
- `blk_exp_out`  out  `cnt_size`  block exponent (minimum zero count), held for all 4 output beats
- `blk_first_out`  out  1  high on beat 0 of each output block

## Operation
- Write side:
  - `wr_cnt` (0..3) and `wr_bank` (0/1).
  - Each `valid_in`-high edge stores the 16 lanes and `zero_cnt_in` into `bank[wr_bank]` at slot `wr_cnt`, updates that bank's running minimum, and increments `wr_cnt`.
  - Beats need not be contiguous: `valid_in` low pauses the write side with no effect.
  - On the edge accepting slot 3: `full[wr_bank]` is set, `wr_cnt` wraps to 0 and `wr_bank` toggles.
  - The stored minimum is min(running min, beat-3 count).
- Read FSM, states IDLE and OUT:
  - IDLE -> OUT when `full[rd_bank]`. Sets `rd_cnt` = 0 and latches the bank minimum into `blk_exp_out`.
  - OUT emits one beat per cycle, slots 0..3.
  - On slot 3: clear `full[rd_bank]` and toggle `rd_bank`.
  - If the other bank is already full, go straight to OUT slot 0 with no bubble; otherwise go to IDLE.
- Alignment per lane: `shift` = `cnt_k` − min, 0..31.
  - `dout` = `din` >>> `shift`, arithmetic right shift with truncation, no rounding.
  - `shift` ≥ `din_size` − 1 (10): output is the sign fill, 0 or −1.
  - No overflow is possible (right shift only).
- Buffer overrun cannot occur. The reader drains 4 beats in 4 cycles, starting one cycle after a bank fills, so it always finishes before the writer can refill that bank. No overflow flag is required.
- Reset, asserted at any time:
  - Clears `wr_cnt`, `rd_cnt`, `wr_bank`, `rd_bank`, `full[*]` and FSM state (to IDLE).
  - Partial blocks are discarded.
  - The buffer contents are not reset.

## Timing
- Reset values: `valid_out` = 0, `dout_re_p` all 0, `blk_exp_out` = 0, `blk_first_out` = 0.
- All outputs are registered.
- Latency: if beat 3 of a block is sampled at edge t, output beat 0 appears after edge t+1. Output beat k appears after edge t+1+k.
- Throughput: sustains one beat per cycle indefinitely. Back-to-back input blocks produce back-to-back output blocks, with `valid_out` continuous.
- `blk_first_out` and `blk_exp_out` change only at output beat 0.
- Simultaneous events: a bank fill and a read-complete on the same edge are legal. `full` set/clear always target different banks on the same edge.

## Structure
- Package `cbfp_pkg`:
  - `ARRAY_SIZE`, `DIN_SIZE`, `CNT_SIZE`, `BEATS_PER_BLOCK`
  - typedefs `sample_t` (signed `DIN_SIZE`), `lane_vec_t` (`sample_t` [`ARRAY_SIZE`]), `zcnt_t`
- Sub-module `cbfp_lane_shift`: one lane of shift-and-clamp, instantiated 16 times. Inputs are `sample_t` and a 5-bit shift.
- Top module holds the banks, counters, minimum tracking and read FSM.

## Test plan
- Single block, all counts 3, lane j of beat k = 10·k + j: outputs equal inputs, `blk_exp_out` = 3, `valid_out` high 4 cycles starting one edge after the beat-3 edge, `blk_first_out` on beat 0 only.
- Counts {2,5,3,4}, lane 0 values {−7, 400, −400, 96}: outputs {−7, 50, −200, 24}, `blk_exp_out` = 2.
- Clamp: counts {0,15,0,0}, beat-1 lanes 511, −1, −512, 0: outputs 0, −1, −1, 0.
- Three back-to-back blocks (12 continuous input beats, counts {1,1,1,1}, {4,2,2,2}, {0,0,0,9}): 12 continuous `valid_out` cycles, exponents 1, 2, 0 in order, no bubble.
- Gapped input, pattern 4 valid / 4 idle repeated for 4 blocks: each output block is 4 beats, blocks spaced 8 cycles apart, values correct.
- Reset asserted after 2 beats of a block, then one full block with counts {6,6,6,6}: exactly 4 output beats with only the new data, `blk_exp_out` = 6.
